// File: rtl/lsu_pkg.sv
// Shared types and access-decoding helpers for the RV32I load/store unit.
// Access legality and store-lane formatting live here so the FSM stays readable.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  // Unsigned variants only exist for loads, so a store with BU/HU is illegal.
  function automatic logic access_bad(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = offset[0];
      F3_W:    bad = (offset != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_byte_en(input logic [2:0] funct3,
                                               input logic [1:0] offset);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << offset;
      F3_H:    be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3,
                                              input logic [31:0] data);
    logic [31:0] lanes;
    case (funct3)
      F3_B:    lanes = {4{data[7:0]}};
      F3_H:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the addressed bytes of a memory word down to bit 0 and extends them
// to 32 bits according to the load's funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  iFunct3,
  input  logic [1:0]  iOffset,
  input  logic [31:0] iWord,
  output logic [31:0] oData
);

  logic [31:0] shifted;

  always_comb begin
    shifted = iWord >> {iOffset, 3'b000};
    case (iFunct3)
      F3_B:    oData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    oData = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   oData = {24'h0, shifted[7:0]};
      F3_HU:   oData = {16'h0, shifted[15:0]};
      default: oData = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns a core load/store into a req/ack data-memory
// transaction, stalling the core until the access completes or times out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oDone,
  output logic        oStall,
  output logic        oMisalign,
  output logic        oTimeout,
  output logic        oMem_Req,
  output logic        oMem_We,
  output logic [31:0] oMem_Addr,
  output logic [3:0]  oMem_ByteEn,
  output logic [31:0] oMem_WrData,
  input  logic        iMem_Ack,
  input  logic [31:0] iMem_RdData
);

  // The counter holds cycles already spent in ACCESS, so the last allowed
  // cycle is the one where it equals TIMEOUT_CYC-1.
  localparam logic [7:0] LAST_CYC = 8'(TIMEOUT_CYC - 1);

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        misalign_q;
  logic        timeout_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  byte_en_q;
  logic [31:0] wr_data_q;
  logic [31:0] rd_data_q;
  logic [31:0] load_data;
  logic        req_bad;
  logic        expire;

  assign req_bad = access_bad(iWe, iFunct3, iAddr[1:0]);
  assign expire  = !iMem_Ack && (cnt == LAST_CYC);

  lsu_load_align u_align (
    .iFunct3 (funct3_q),
    .iOffset (offset_q),
    .iWord   (iMem_RdData),
    .oData   (load_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (iReq) begin
          state_next = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (iMem_Ack || expire) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request attributes are frozen at capture so the memory sees stable
  // address/lanes for the whole access even if the core changes its inputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      cnt        <= 8'h0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      byte_en_q  <= 4'h0;
      wr_data_q  <= 32'h0;
      rd_data_q  <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (iReq) begin
            cnt        <= 8'h0;
            we_q       <= iWe;
            funct3_q   <= iFunct3;
            offset_q   <= iAddr[1:0];
            misalign_q <= req_bad;
            timeout_q  <= 1'b0;
            mem_addr_q <= {iAddr[31:2], 2'b00};
            byte_en_q  <= iWe ? store_byte_en(iFunct3, iAddr[1:0]) : 4'b1111;
            wr_data_q  <= store_lanes(iFunct3, iWrData);
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'h1;
          if (expire) begin
            timeout_q <= 1'b1;
          end
          if (iMem_Ack && !we_q) begin
            rd_data_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign oMem_Req    = (state == ACCESS);
  assign oMem_We     = we_q && (state == ACCESS);
  assign oMem_Addr   = mem_addr_q;
  assign oMem_ByteEn = byte_en_q;
  assign oMem_WrData = wr_data_q;
  assign oRdData     = rd_data_q;
  assign oDone       = (state == RESP);
  assign oMisalign   = (state == RESP) && misalign_q;
  assign oTimeout    = (state == RESP) && timeout_q;
  assign oStall      = (state == ACCESS) || ((state == IDLE) && iReq);

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the RV32I datapath. It consumes the ALU-computed data address, the store data and funct3, then drives a word-addressed data memory through a req/ack handshake. It produces byte enables and replicated store lanes, and returns aligned, sign- or zero-extended load data. It stalls the core until each access completes, and flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYC, 255, max cycles oMem_Req may stay high without iMem_Ack before the access aborts (range 1..255).

Ports:
iClk  input  1  system clock, rising edge
iRst_n  input  1  asynchronous active-low reset
iReq  input  1  core access request; held by core until oDone
iWe  input  1  1 = store, 0 = load; sampled with iReq
iFunct3  input  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
iAddr  input  32  byte address (datapath oData_Addr)
iWrData  input  32  store data (datapath oData_WrData)
oRdData  output  32  extended load result; valid when oDone=1 and load
oDone  output  1  one-cycle completion pulse
oStall  output  1  core must freeze PC/regfile write
oMisalign  output  1  pulses with oDone when access was misaligned or funct3 illegal
oTimeout  output  1  pulses with oDone when memory never acked
oMem_Req  output  1  memory request
oMem_We  output  1  memory write enable
oMem_Addr  output  32  word address {addr[31:2],2'b00}
oMem_ByteEn  output  4  byte-lane enables (stores; 4'b1111 on loads)
oMem_WrData  output  32  lane-replicated store data
iMem_Ack  input  1  memory accepts/completes access
iMem_RdData  input  32  read word; valid in the iMem_Ack cycle

Behaviour:
- Reset is asynchronous, active-low. It forces state IDLE, counter 0, and all outputs 0 (oRdData, oMem_Addr and oMem_WrData = 32'h0).
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on an edge with iReq=1, capture iWe, iFunct3, iAddr and iWrData.
  - Misaligned or illegal access goes to RESP with the misalign flag set.
  - Misaligned = H-type with addr[0]=1, or W-type with addr[1:0]≠0.
  - Illegal funct3 = loads 011/110/111; stores other than 000/001/010.
  - Otherwise go to ACCESS.
- ACCESS: oMem_Req=1, and oMem_We/Addr/ByteEn/WrData are held stable.
  - Counter increments each cycle.
  - iMem_Ack=1 (allowed on the first ACCESS cycle): capture extended load data and go to RESP.
  - Counter reaching TIMEOUT_CYC without ack: drop request, go to RESP with timeout flag.
- RESP: oDone=1 for one cycle; oMisalign/oTimeout valid here only; return to IDLE.
  - oRdData is registered and holds its value until the next load completes.
  - Stores leave oRdData unchanged.
- oStall = (state≠IDLE && state≠RESP) || (state==IDLE && iReq). It is combinational and low in the RESP cycle, so the core advances.
- Latency: iReq sampled at edge N → oMem_Req high from N+1. Ack at edge M → oDone in cycle M+1. Minimum is 2 cycles for an aligned access; misaligned access has oDone at N+1 with no memory request.
- Store lanes, with o = addr[1:0]:
  - SB: ByteEn = 4'b0001<<o, WrData = {4{data[7:0]}}.
  - SH: ByteEn = 4'b0011<<o, WrData = {2{data[15:0]}}.
  - SW: ByteEn = 4'b1111, WrData = data.
- Load extract: s = iMem_RdData >> (8*o).
  - LB: sign-extend s[7:0]; LH: sign-extend s[15:0]; LW: s.
  - LBU / LHU: zero-extend s[7:0] / s[15:0].
- iMem_Ack outside ACCESS is ignored. iReq falling mid-access is ignored; the access completes.
- iRst_n asserted mid-ACCESS drops oMem_Req immediately (asynchronous); no oDone is produced.
- Back-to-back: iReq still high in the RESP cycle is not sampled; a new access starts from IDLE on the next edge.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - typedef enum logic [1:0] lsu_state_t {IDLE, ACCESS, RESP}.
- One combinational sub-module, lsu_load_align (iFunct3, iOffset[1:0], iWord → oData), keeps extraction and sign-extension separately testable.

Test Plan:
- SB, addr 0x1001, data 0x000000AB, ack on first ACCESS cycle → ByteEn=4'b0010, WrData=0xABABABAB, Addr=0x1000, oDone 2 cycles after iReq edge.
- Loads with memory word 0x80FF1234:
  - LB addr 0x3 → oRdData=0xFFFFFF80.
  - LHU addr 0x2 → 0x000080FF.
  - LH addr 0x0 → 0x00001234.
- LW addr 0x6 → oMisalign=1 with oDone one cycle later, oMem_Req never asserted, oRdData unchanged.
- TIMEOUT_CYC=4, load with no ack → oMem_Req high exactly 4 cycles, then oDone=1 with oTimeout=1 and oStall released.
- Ack delayed 3 cycles → oStall high throughout, oMem_* stable, oDone exactly one cycle after ack; iReq dropped mid-wait does not abort.
- Reset pulse during ACCESS → oMem_Req=0 asynchronously, no oDone, all outputs 0; the next iReq starts a clean access.
